// File: rtl/register_file_arbiter.sv
// Round-robin arbiter sharing the ports of a multi-port register file among
// several requesters, with write-conflict filtering and one-cycle read return.
module register_file_arbiter #(
    parameter int DATA_WIDTH       = 32,
    parameter int NUM_REGISTERS    = 3,
    parameter int READ_WRITE_PORTS = 2,
    parameter int NUM_REQUESTERS   = 4,
    localparam int AW = (NUM_REGISTERS > 1) ? $clog2(NUM_REGISTERS) : 1
) (
    input  logic                                       clk_i,
    input  logic                                       reset_n_i,
    input  logic [NUM_REQUESTERS-1:0]                  req_valid_i,
    input  logic [NUM_REQUESTERS-1:0]                  req_write_i,
    input  logic [NUM_REQUESTERS*AW-1:0]               req_addr_i,
    input  logic [NUM_REQUESTERS*DATA_WIDTH-1:0]       req_data_i,
    output logic [NUM_REQUESTERS-1:0]                  req_ready_o,
    output logic [NUM_REQUESTERS-1:0]                  rsp_valid_o,
    output logic [NUM_REQUESTERS-1:0]                  rsp_error_o,
    output logic [NUM_REQUESTERS*DATA_WIDTH-1:0]       rsp_data_o,
    output logic [NUM_REGISTERS*READ_WRITE_PORTS-1:0]  rf_register_select_o,
    output logic [READ_WRITE_PORTS-1:0]                rf_write_select_o,
    output logic [DATA_WIDTH*READ_WRITE_PORTS-1:0]     rf_data_o,
    input  logic [DATA_WIDTH*READ_WRITE_PORTS-1:0]     rf_data_i
);

    localparam int P  = READ_WRITE_PORTS;
    localparam int R  = NUM_REQUESTERS;
    localparam int DW = DATA_WIDTH;
    localparam int NR = NUM_REGISTERS;
    localparam int PW = (P > 1) ? $clog2(P) : 1;
    localparam int RW = (R > 1) ? $clog2(R) : 1;

    logic [RW-1:0]     r_rr;
    logic [NR*P-1:0]   r_sel;
    logic [P-1:0]      r_wsel;
    logic [DW*P-1:0]   r_wdata;
    logic [R-1:0]      r_rsp_valid;
    logic [R-1:0]      r_rsp_err;
    logic [PW-1:0]     r_port [R];

    logic [R-1:0]      w_ready;
    logic [R-1:0]      w_inrange;
    logic [PW-1:0]     w_port [R];
    logic [RW-1:0]     w_next_rr;
    logic [P-1:0]      w_pvalid;
    logic [P-1:0]      w_pwrite;
    logic [AW-1:0]     w_paddr [P];
    logic [DW-1:0]     w_pdata [P];

    always_comb begin
        for (int r = 0; r < R; r++) begin
            w_inrange[r] = (int'(req_addr_i[r*AW +: AW]) < NR);
        end
    end

    // Scan from the round-robin pointer; out-of-range requests are granted
    // without taking a port so they can be answered with an error.
    always_comb begin
        int            used;
        int            idx;
        logic [AW-1:0] addr;
        logic          conflict;
        used      = 0;
        idx       = 0;
        addr      = '0;
        conflict  = 1'b0;
        w_ready   = '0;
        w_next_rr = r_rr;
        w_pvalid  = '0;
        w_pwrite  = '0;
        for (int p = 0; p < P; p++) begin
            w_paddr[p] = '0;
            w_pdata[p] = '0;
        end
        for (int r = 0; r < R; r++) begin
            w_port[r] = '0;
        end
        for (int k = 0; k < R; k++) begin
            idx      = (int'(r_rr) + k) % R;
            addr     = req_addr_i[idx*AW +: AW];
            conflict = 1'b0;
            for (int p = 0; p < P; p++) begin
                if (p < used && w_pwrite[p] && w_paddr[p] == addr) begin
                    conflict = 1'b1;
                end
            end
            if (reset_n_i && req_valid_i[idx]) begin
                if (!w_inrange[idx]) begin
                    w_ready[idx] = 1'b1;
                    w_next_rr    = RW'((idx + 1) % R);
                end else if (used < P && !(req_write_i[idx] && conflict)) begin
                    w_ready[idx] = 1'b1;
                    w_port[idx]  = PW'(used);
                    for (int p = 0; p < P; p++) begin
                        if (p == used) begin
                            w_pvalid[p] = 1'b1;
                            w_pwrite[p] = req_write_i[idx];
                            w_paddr[p]  = addr;
                            w_pdata[p]  = req_data_i[idx*DW +: DW];
                        end
                    end
                    used      = used + 1;
                    w_next_rr = RW'((idx + 1) % R);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_rr        <= '0;
            r_sel       <= '0;
            r_wsel      <= '0;
            r_wdata     <= '0;
            r_rsp_valid <= '0;
            r_rsp_err   <= '0;
            for (int r = 0; r < R; r++) begin
                r_port[r] <= '0;
            end
        end else begin
            r_rr <= w_next_rr;
            for (int p = 0; p < P; p++) begin
                r_sel[p*NR +: NR]   <= w_pvalid[p] ? (NR'(1) << w_paddr[p]) : '0;
                r_wsel[p]           <= w_pvalid[p] & w_pwrite[p];
                r_wdata[p*DW +: DW] <= w_pvalid[p] ? w_pdata[p] : '0;
            end
            // In-range writes complete silently; reads and errors respond.
            for (int r = 0; r < R; r++) begin
                r_rsp_valid[r] <= w_ready[r] & (~w_inrange[r] | ~req_write_i[r]);
                r_rsp_err[r]   <= w_ready[r] & ~w_inrange[r];
                r_port[r]      <= w_port[r];
            end
        end
    end

    always_comb begin
        for (int r = 0; r < R; r++) begin
            rsp_data_o[r*DW +: DW] = (r_rsp_valid[r] && !r_rsp_err[r]) ?
                                     rf_data_i[int'(r_port[r])*DW +: DW] : '0;
        end
    end

    assign req_ready_o          = w_ready;
    assign rsp_valid_o          = r_rsp_valid;
    assign rsp_error_o          = r_rsp_err;
    assign rf_register_select_o = r_sel;
    assign rf_write_select_o    = r_wsel;
    assign rf_data_o            = r_wdata;

endmodule

// File: tb/tb_register_file_arbiter.sv
// Bench for register_file_arbiter: directed scenarios plus random traffic
// checked against a queue-based grant model and a behavioural register file.
module tb_register_file_arbiter;

    localparam int DW   = 32;
    localparam int NREG = 3;
    localparam int P    = 2;
    localparam int R    = 4;
    localparam int AW   = 2;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic [R-1:0]         req_valid = '0;
    logic [R-1:0]         req_write = '0;
    logic [R*AW-1:0]      req_addr = '0;
    logic [R*DW-1:0]      req_data = '0;
    logic [R-1:0]         req_ready_o;
    logic [R-1:0]         rsp_valid_o;
    logic [R-1:0]         rsp_error_o;
    logic [R*DW-1:0]      rsp_data_o;
    logic [NREG*P-1:0]    rf_sel_o;
    logic [P-1:0]         rf_wsel_o;
    logic [DW*P-1:0]      rf_wdata_o;
    logic [DW*P-1:0]      rf_rdata;

    logic [DW-1:0]        rf_mem [NREG] = '{default: '0};
    logic [DW-1:0]        mdl_regs [NREG] = '{default: '0};
    int                   m_rr = 0;
    logic [R*DW-1:0]      exp_q [$];
    int                   n_checks = 0;
    int                   n_pass = 0;

    register_file_arbiter #(
        .DATA_WIDTH(DW), .NUM_REGISTERS(NREG),
        .READ_WRITE_PORTS(P), .NUM_REQUESTERS(R)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .req_valid_i(req_valid), .req_write_i(req_write),
        .req_addr_i(req_addr), .req_data_i(req_data),
        .req_ready_o(req_ready_o), .rsp_valid_o(rsp_valid_o),
        .rsp_error_o(rsp_error_o), .rsp_data_o(rsp_data_o),
        .rf_register_select_o(rf_sel_o), .rf_write_select_o(rf_wsel_o),
        .rf_data_o(rf_wdata_o), .rf_data_i(rf_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural register file: combinational read, write on clock edge.
    always_comb begin
        for (int p = 0; p < P; p++) begin
            rf_rdata[p*DW +: DW] = '0;
            for (int i = 0; i < NREG; i++) begin
                if (rf_sel_o[p*NREG+i]) rf_rdata[p*DW +: DW] = rf_rdata[p*DW +: DW] | rf_mem[i];
            end
        end
    end

    always @(posedge clk) begin
        for (int p = 0; p < P; p++) begin
            for (int i = 0; i < NREG; i++) begin
                if (rf_wsel_o[p] && rf_sel_o[p*NREG+i]) rf_mem[i] <= rf_wdata_o[p*DW +: DW];
            end
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic clear_reqs();
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_data  = '0;
    endtask

    task automatic set_req(input int r, input bit v, input bit w, input int a, input logic [DW-1:0] d);
        req_valid[r]         = v;
        req_write[r]         = w;
        req_addr[r*AW +: AW] = AW'(a);
        req_data[r*DW +: DW] = d;
    endtask

    // Grant model: walk a queue of requesters in pointer order, hand out
    // ports, refuse duplicate write targets, answer reads from pre-cycle state.
    task automatic model_step(output logic [R-1:0] e_ready, output logic [NREG*P-1:0] e_sel,
                              output logic [P-1:0] e_wsel, output logic [DW*P-1:0] e_wdata,
                              output logic [R-1:0] e_rv, output logic [R-1:0] e_re,
                              output logic [R*DW-1:0] e_rd);
        int            scan [$];
        int            wr_addr [$];
        logic [DW-1:0] wr_data [$];
        int            nports;
        int            last;
        e_ready = '0; e_sel = '0; e_wsel = '0; e_wdata = '0;
        e_rv = '0; e_re = '0; e_rd = '0;
        nports = 0;
        last   = -1;
        for (int k = 0; k < R; k++) scan.push_back((m_rr + k) % R);
        while (scan.size() > 0) begin
            int            r;
            int            a;
            bit            w;
            bit            clash;
            logic [DW-1:0] d;
            r = scan.pop_front();
            if (!req_valid[r]) continue;
            a = int'(req_addr[r*AW +: AW]);
            w = req_write[r];
            d = req_data[r*DW +: DW];
            if (a >= NREG) begin
                e_ready[r] = 1'b1; e_rv[r] = 1'b1; e_re[r] = 1'b1;
                last = r;
                continue;
            end
            if (nports == P) continue;
            clash = 1'b0;
            foreach (wr_addr[i]) if (w && wr_addr[i] == a) clash = 1'b1;
            if (clash) continue;
            e_ready[r]                = 1'b1;
            e_sel[nports*NREG + a]    = 1'b1;
            e_wsel[nports]            = w;
            e_wdata[nports*DW +: DW]  = d;
            if (w) begin
                wr_addr.push_back(a);
                wr_data.push_back(d);
            end else begin
                e_rv[r]             = 1'b1;
                e_rd[r*DW +: DW]    = mdl_regs[a];
            end
            nports++;
            last = r;
        end
        foreach (wr_addr[i]) mdl_regs[wr_addr[i]] = wr_data[i];
        if (last >= 0) m_rr = (last + 1) % R;
    endtask

    // Called just after a rising edge with inputs already applied.
    task automatic run_cycle();
        logic [R-1:0]      e_ready;
        logic [NREG*P-1:0] e_sel;
        logic [P-1:0]      e_wsel;
        logic [DW*P-1:0]   e_wdata;
        logic [R-1:0]      e_rv;
        logic [R-1:0]      e_re;
        logic [R*DW-1:0]   e_rd;
        model_step(e_ready, e_sel, e_wsel, e_wdata, e_rv, e_re, e_rd);
        exp_q.push_back(e_rd);
        #1;
        chk("ready", req_ready_o, e_ready);
        @(posedge clk);
        #1;
        chk("rf_sel", rf_sel_o, e_sel);
        chk("rf_wsel", rf_wsel_o, e_wsel);
        chk("rf_wdata", rf_wdata_o, e_wdata);
        chk("rsp_valid", rsp_valid_o, e_rv);
        chk("rsp_error", rsp_error_o, e_re);
        chk("rsp_data", rsp_data_o, exp_q.pop_front());
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ready"}, req_ready_o, '0);
        chk({tag, "_rsp_valid"}, rsp_valid_o, '0);
        chk({tag, "_rsp_error"}, rsp_error_o, '0);
        chk({tag, "_rsp_data"}, rsp_data_o, '0);
        chk({tag, "_rf_sel"}, rf_sel_o, '0);
        chk({tag, "_rf_wsel"}, rf_wsel_o, '0);
        chk({tag, "_rf_wdata"}, rf_wdata_o, '0);
    endtask

    initial begin
        #2;
        check_all_zero("init");
        #10 reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Two writes to reg 2: requester 0 wins, requester 2 follows.
        clear_reqs(); set_req(0, 1, 1, 2, 32'hA); set_req(2, 1, 1, 2, 32'hB);
        run_cycle();
        clear_reqs(); set_req(2, 1, 1, 2, 32'hB);
        run_cycle();
        clear_reqs(); set_req(0, 1, 0, 2, 0);
        run_cycle();
        chk("conflict_readback", rsp_data_o[DW-1:0], 32'hB);

        // Read and write of reg 0 granted together.
        clear_reqs(); set_req(0, 1, 1, 0, 32'h55); set_req(1, 1, 0, 0, 0);
        run_cycle();
        chk("raw_old_value", rsp_data_o[DW +: DW], 32'h0);
        clear_reqs(); set_req(1, 1, 0, 0, 0);
        run_cycle();
        chk("raw_new_value", rsp_data_o[DW +: DW], 32'h55);

        // All four read reg 1.
        clear_reqs(); set_req(3, 1, 1, 1, 32'h1234_5678);
        run_cycle();
        for (int c = 0; c < 4; c++) begin
            clear_reqs();
            for (int r = 0; r < R; r++) set_req(r, 1, 0, 1, 0);
            run_cycle();
        end

        // Out-of-range read beside a normal read.
        clear_reqs(); set_req(3, 1, 0, 3, 0); set_req(0, 1, 0, 1, 0);
        run_cycle();
        chk("oor_error", rsp_error_o[3], 1'b1);
        chk("oor_data", rsp_data_o[3*DW +: DW], 32'h0);

        // Lone requester 2 for five cycles.
        for (int c = 0; c < 5; c++) begin
            clear_reqs(); set_req(2, 1, c % 2, c % 3, $urandom);
            run_cycle();
        end

        // Random traffic including out-of-range addresses.
        for (int c = 0; c < 60; c++) begin
            clear_reqs();
            for (int r = 0; r < R; r++) begin
                set_req(r, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3), $urandom);
            end
            run_cycle();
        end

        // Reset while read responses are in flight.
        clear_reqs();
        for (int r = 0; r < R; r++) set_req(r, 1, 0, 1, 0);
        run_cycle();
        reset_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        clear_reqs();
        @(negedge clk);
        reset_n = 1'b1;
        m_rr = 0;
        @(posedge clk);
        #1;
        for (int r = 0; r < R; r++) set_req(r, 1, 0, 1, 0);
        #1;
        chk("post_reset_first_grant", req_ready_o, 4'b0011);
        run_cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
